bram32: RTL and testbench

- Simple dual-port synchronous block RAM: 1024 words × 32 bits.
- Used as the instruction memory of the rv32i single-core CPU.
- Write port (A) loads the program; read port (B) supplies instructions to fetch.
- Written to infer a single FPGA BRAM primitive (Zybo Z7-20).

---
 rtl/bram32.sv | 50 +++++
 tb/tb_bram32.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bram32.sv
// rtl/bram32.sv - 1024x32 simple dual-port instruction BRAM, write port A, registered read port B
module bram32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_dat,
    input  logic                  w_enb,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic                  r_enb,
    output logic [DATA_WIDTH-1:0] r_dat
);

    // Array shape must stay a plain 1-D word array so it maps onto a single block RAM.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [DATA_WIDTH-1:0] r_dat_q;
    logic [DATA_WIDTH-1:0] r_dat_d;

    // Write port: independent of reset so a program load can proceed while the core is held.
    always_ff @(posedge clk) begin
        if (w_enb) begin
            mem[w_addr] <= w_dat;
        end
    end

    // Next read data: new word on an enabled read, otherwise hold.
    always_comb begin
        r_dat_d = r_dat_q;
        if (r_enb) begin
            r_dat_d = mem[r_addr];
        end
    end

    // Read register: cleared by reset; sampling the array before this edge's write gives read-first collisions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dat_q <= '0;
        end else begin
            r_dat_q <= r_dat_d;
        end
    end

    assign r_dat = r_dat_q;

endmodule

// File: tb/tb_bram32.sv
// tb/tb_bram32.sv - directed vector bench for bram32
module tb_bram32;

    logic        clk;
    logic        rst;
    logic [9:0]  w_addr;
    logic [31:0] w_dat;
    logic        w_enb;
    logic [9:0]  r_addr;
    logic        r_enb;
    logic [31:0] r_dat;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic        rst;
        logic        w_enb;
        logic [9:0]  w_addr;
        logic [31:0] w_dat;
        logic        r_enb;
        logic [9:0]  r_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    bram32 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .DEPTH(1024),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .w_addr(w_addr),
        .w_dat(w_dat),
        .w_enb(w_enb),
        .r_addr(r_addr),
        .r_enb(r_enb),
        .r_dat(r_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic we, input logic [9:0] wa, input logic [31:0] wd,
                         input logic re, input logic [9:0] ra);
        rst    = rs;
        w_enb  = we;
        w_addr = wa;
        w_dat  = wd;
        r_enb  = re;
        r_addr = ra;
    endtask

    task automatic add(input string n, input logic rs, input logic we, input logic [9:0] wa,
                       input logic [31:0] wd, input logic re, input logic [9:0] ra, input logic [31:0] e);
        vec_t v;
        v.name = n; v.rst = rs; v.w_enb = we; v.w_addr = wa; v.w_dat = wd;
        v.r_enb = re; v.r_addr = ra; v.exp = e;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] I0 = 32'h00500093;
    localparam logic [31:0] I1 = 32'h00A00113;
    localparam logic [31:0] I2 = 32'h002081B3;
    localparam logic [31:0] I3 = 32'hFE000EE3;

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 10'd0);

        //   name            rst we  w_addr   w_dat          re  r_addr   expected r_dat after edge
        add("reset0",        0,  0,  10'h000, 32'h0,        1,  10'h000, 32'h0);
        add("reset1",        0,  0,  10'h000, 32'h0,        1,  10'h000, 32'h0);
        add("release",       1,  0,  10'h000, 32'h0,        0,  10'h000, 32'h0);
        add("load0",         1,  1,  10'h000, I0,           0,  10'h000, 32'h0);
        add("load1",         1,  1,  10'h001, I1,           0,  10'h000, 32'h0);
        add("load2",         1,  1,  10'h002, I2,           0,  10'h000, 32'h0);
        add("load3",         1,  1,  10'h003, I3,           0,  10'h000, 32'h0);
        add("fetch0",        1,  0,  10'h000, 32'h0,        1,  10'h000, I0);
        add("fetch1",        1,  0,  10'h000, 32'h0,        1,  10'h001, I1);
        add("fetch2",        1,  0,  10'h000, 32'h0,        1,  10'h002, I2);
        add("fetch3",        1,  0,  10'h000, 32'h0,        1,  10'h003, I3);
        add("hold_rd2",      1,  0,  10'h000, 32'h0,        1,  10'h002, I2);
        add("hold_a",        1,  0,  10'h000, 32'h0,        0,  10'h003, I2);
        add("hold_b",        1,  0,  10'h000, 32'h0,        0,  10'h003, I2);
        add("hold_c",        1,  0,  10'h000, 32'h0,        0,  10'h003, I2);
        add("col_pre",       1,  1,  10'h005, 32'h11111111, 0,  10'h000, I2);
        add("collision",     1,  1,  10'h005, 32'h22222222, 1,  10'h005, 32'h11111111);
        add("col_after",     1,  0,  10'h000, 32'h0,        1,  10'h005, 32'h22222222);
        add("wr_3fe",        1,  1,  10'h3FE, 32'hDEADBEEF, 1,  10'h005, 32'h22222222);
        add("wr_3ff",        1,  1,  10'h3FF, 32'hCAFEBABE, 0,  10'h000, 32'h22222222);
        add("wr0_rd3fe",     1,  1,  10'h000, 32'h12345678, 1,  10'h3FE, 32'hDEADBEEF);
        add("rd_000",        1,  0,  10'h000, 32'h0,        1,  10'h000, 32'h12345678);
        add("rd_3ff",        1,  0,  10'h000, 32'h0,        1,  10'h3FF, 32'hCAFEBABE);
        add("mid_reset",     0,  0,  10'h000, 32'h0,        1,  10'h000, 32'h0);
        add("retain_3ff",    1,  0,  10'h000, 32'h0,        1,  10'h3FF, 32'hCAFEBABE);
        add("wr_in_reset",   0,  1,  10'h007, 32'h77777777, 1,  10'h3FF, 32'h0);
        add("rd_7",          1,  0,  10'h000, 32'h0,        1,  10'h007, 32'h77777777);
        add("rd_3fe_again",  1,  0,  10'h000, 32'h0,        1,  10'h3FE, 32'hDEADBEEF);
        add("indep_wr_rd",   1,  1,  10'h010, 32'hABCD0001, 1,  10'h000, 32'h12345678);
        add("rd_010",        1,  0,  10'h000, 32'h0,        1,  10'h010, 32'hABCD0001);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].w_enb, vecs[i].w_addr, vecs[i].w_dat, vecs[i].r_enb, vecs[i].r_addr);
            @(posedge clk);
            #1;
            check(vecs[i].name, r_dat, vecs[i].exp);
        end

        // Latency: output must not change before the edge that samples the new address.
        @(negedge clk);
        drive(1'b1, 1'b0, 10'h000, 32'h0, 1'b1, 10'h3FF);
        #2;
        check("lat_before_edge", r_dat, 32'hABCD0001);
        @(posedge clk);
        #1;
        check("lat_after_edge", r_dat, 32'hCAFEBABE);

        // Back-to-back collisions on one address: each read sees the word from the previous edge.
        @(negedge clk);
        drive(1'b1, 1'b1, 10'h020, 32'hA5A5A5A5, 1'b0, 10'h020);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 10'h020, 32'h5A5A5A5A, 1'b1, 10'h020);
        @(posedge clk);
        #1;
        check("col2_first", r_dat, 32'hA5A5A5A5);
        @(negedge clk);
        drive(1'b1, 1'b1, 10'h020, 32'h0F0F0F0F, 1'b1, 10'h020);
        @(posedge clk);
        #1;
        check("col2_second", r_dat, 32'h5A5A5A5A);
        @(negedge clk);
        drive(1'b1, 1'b0, 10'h000, 32'h0, 1'b1, 10'h020);
        @(posedge clk);
        #1;
        check("col2_final", r_dat, 32'h0F0F0F0F);

        // Disabled write leaves memory untouched.
        @(negedge clk);
        drive(1'b1, 1'b0, 10'h020, 32'hFFFFFFFF, 1'b0, 10'h020);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 10'h000, 32'h0, 1'b1, 10'h020);
        @(posedge clk);
        #1;
        check("no_write_when_disabled", r_dat, 32'h0F0F0F0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
